ghost_lut_arbiter: RTL and testbench
====================================

// Module: ghost_lut_arbiter
// PURPOSE
//  Shares the single-read-port 768x3 ghost sprite LUT between the four ghost renderers (blinky, pinky, inky, clyde).
//  Round-robin arbitration, one lookup per clock, 2-stage pipeline. Decodes the raw 3-bit LUT code into a
//  final pixel class using the requester's direction and a frill animation frame generated here.
//  Sits between the ghost sprite address generators and the LUT; output feeds the ghost colour mux.
// PARAMETERS
//  ADDR_W     10   LUT address width (sprite = addr[9:8], row = addr[7:4], col = addr[3:0])
//  LUT_DEPTH  768  valid LUT entries; addresses >= LUT_DEPTH decode to TRANS
//  FRILL_DIV  8    frame_tick pulses per frill_frame toggle (>=1)
// PORTS
//  clk            in   1       system clock
//  rst_n          in   1       synchronous reset, active low
//  req            in   4       lookup request, bit0 blinky .. bit3 clyde; held until granted
//  blinky_addr    in   10      LUT address for requester 0 (pinky_addr/inky_addr/clyde_addr likewise, 1..3)
//  dir            in   4       per-requester direction bit: 0 = right/up, 1 = left/down; sampled with addr at grant
//  frame_tick     in   1       one-cycle pulse, once per video frame
//  gnt            out  4       one-hot grant, combinational from req and rr pointer
//  lut_addr       out  10      registered address to the LUT
//  lut_pixel      in   3       combinational LUT data for lut_addr
//  rsp_valid      out  4       one-hot response strobe, tagged to the requester
//  rsp_class      out  2       0 TRANS, 1 BODY, 2 EYE (pupil/blue), 3 WHITE
//  frill_frame    out  1       current frill animation frame
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): lut_addr=0, rsp_valid=0, rsp_class=0, frill_frame=0, frill counter=0,
//   stage valids cleared, rr pointer = 3 (blinky has top priority next). gnt forced to 0 while rst_n=0.
//   Reset mid-operation discards in-flight lookups; no rsp_valid for them.
//  Arbitration (cycle N): priority starts at (last_granted+1) mod 4 and wraps; at most one gnt bit set;
//   gnt=0 if req=0. On grant: rr pointer <= granted index; addr, dir bit and tag captured into stage 1.
//  Stage 1 (cycle N+1): lut_addr = captured addr; lut_pixel valid same cycle.
//  Stage 2 (cycle N+2): rsp_valid[tag]=1 for one cycle, rsp_class = decode(lut_pixel, row, dir, frame).
//   Latency gnt -> rsp_valid = 2 cycles; throughput 1 lookup/cycle; no backpressure on responses.
//  Requester must deassert or change req/addr the cycle after its gnt; a held req is treated as new.
//  Decode (row = addr[7:4]; frame = frill_frame sampled in stage 1):
//   addr >= LUT_DEPTH -> TRANS.  000 -> TRANS.  001 -> BODY.  111 -> TRANS.
//   row 13 or 14 (frill rows): 010 -> BODY if frame=0 else TRANS; 011 -> BODY if frame=1 else TRANS;
//     100..110 in frill rows -> BODY.
//   other rows: 010 -> EYE; 011 -> WHITE if dir=0 else BODY; 100 -> EYE if dir=0 else BODY;
//     101 -> WHITE if dir=1 else BODY; 110 -> EYE if dir=1 else BODY.
//  Frill: counter increments on frame_tick; on reaching FRILL_DIV-1 with frame_tick, wraps to 0 and
//   toggles frill_frame. frame_tick during a lookup affects only lookups entering stage 1 afterwards.
// TESTING
//  1 Reset: hold rst_n=0 with req=4'hF -> gnt=0, rsp_valid=0, lut_addr=0, frill_frame=0.
//  2 Round robin: req=4'hF held 8 cycles after reset -> gnt 1,2,4,8,1,2,4,8; rsp_valid same order, 2 cycles later.
//  3 Decode: blinky addr 0x045 (WHT0 row4) dir=0 -> WHITE; dir=1 -> BODY; addr 0x104 (BLU0) dir=0 -> EYE.
//  4 Frill: FRILL_DIV=8, 8 frame_tick pulses -> frill_frame 0->1; addr 0x0D5 (FRL0) -> BODY before, TRANS after.
//  5 Out of range: pinky addr 0x300 and 0x3FF -> rsp_valid[1]=1, rsp_class=TRANS.
//  6 Reset mid-flight: grant inky, pull rst_n low next cycle -> no rsp_valid[2]; after release req=4'h8 -> gnt=8.

Source files
------------

// File: rtl/ghost_lut_arbiter.sv
// Ghost sprite LUT arbiter: shares the single-read-port 768x3 sprite LUT between
// the four ghost renderers. Round-robin grant, one lookup per clock, 2-stage
// pipeline. The raw 3-bit LUT code is decoded into a pixel class using the
// requester's direction and the frill animation frame generated here.
module ghost_lut_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int LUT_DEPTH = 768,
    parameter int FRILL_DIV = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req,
    input  logic [ADDR_W-1:0] blinky_addr,
    input  logic [ADDR_W-1:0] pinky_addr,
    input  logic [ADDR_W-1:0] inky_addr,
    input  logic [ADDR_W-1:0] clyde_addr,
    input  logic [3:0]        dir,
    input  logic              frame_tick,
    output logic [3:0]        gnt,
    output logic [ADDR_W-1:0] lut_addr,
    input  logic [2:0]        lut_pixel,
    output logic [3:0]        rsp_valid,
    output logic [1:0]        rsp_class,
    output logic              frill_frame
);

    localparam int CNT_W = (FRILL_DIV > 1) ? $clog2(FRILL_DIV) : 1;

    localparam logic [1:0] CLS_TRANS = 2'd0;
    localparam logic [1:0] CLS_BODY  = 2'd1;
    localparam logic [1:0] CLS_EYE   = 2'd2;
    localparam logic [1:0] CLS_WHITE = 2'd3;

    // Pixel class decode. Frill rows (13, 14) animate between two frames; the
    // other rows swap eye/white placement according to the ghost direction.
    function automatic logic [1:0] decode_pixel(
        input logic [2:0]        code,
        input logic [ADDR_W-1:0] addr,
        input logic              d,
        input logic              frame
    );
        logic [3:0] row;
        logic [1:0] cls;
        row = addr[7:4];
        cls = CLS_TRANS;
        if (32'(addr) >= 32'(LUT_DEPTH)) begin
            cls = CLS_TRANS;
        end else if ((row == 4'd13) || (row == 4'd14)) begin
            case (code)
                3'b000:  cls = CLS_TRANS;
                3'b001:  cls = CLS_BODY;
                3'b010:  cls = frame ? CLS_TRANS : CLS_BODY;
                3'b011:  cls = frame ? CLS_BODY : CLS_TRANS;
                3'b100:  cls = CLS_BODY;
                3'b101:  cls = CLS_BODY;
                3'b110:  cls = CLS_BODY;
                3'b111:  cls = CLS_TRANS;
                default: cls = CLS_TRANS;
            endcase
        end else begin
            case (code)
                3'b000:  cls = CLS_TRANS;
                3'b001:  cls = CLS_BODY;
                3'b010:  cls = CLS_EYE;
                3'b011:  cls = d ? CLS_BODY  : CLS_WHITE;
                3'b100:  cls = d ? CLS_BODY  : CLS_EYE;
                3'b101:  cls = d ? CLS_WHITE : CLS_BODY;
                3'b110:  cls = d ? CLS_EYE   : CLS_BODY;
                3'b111:  cls = CLS_TRANS;
                default: cls = CLS_TRANS;
            endcase
        end
        return cls;
    endfunction

    // Round-robin pointer (last granted index) and pipeline registers.
    logic [1:0]        rr_q,        rr_d;
    logic              s1_valid_q,  s1_valid_d;
    logic [ADDR_W-1:0] s1_addr_q,   s1_addr_d;
    logic              s1_dir_q,    s1_dir_d;
    logic [1:0]        s1_tag_q,    s1_tag_d;
    logic [3:0]        rsp_valid_q, rsp_valid_d;
    logic [1:0]        rsp_class_q, rsp_class_d;
    logic [CNT_W-1:0]  frill_cnt_q, frill_cnt_d;
    logic              frill_q,     frill_d;

    logic [7:0]        req_dbl_s;
    logic [2:0]        rot_sh_s;
    logic [3:0]        req_rot_s;
    logic [1:0]        gnt_off_s;
    logic              gnt_any_s;
    logic [1:0]        gnt_idx_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [1:0]        cls_s;

    // Rotate requests so bit 0 is the highest-priority requester, then pick the first set bit.
    always_comb begin
        req_dbl_s = {req, req};
        rot_sh_s  = {1'b0, rr_q} + 3'd1;
        req_rot_s = req_dbl_s[rot_sh_s +: 4];
        gnt_off_s = 2'd0;
        gnt_any_s = 1'b1;
        casez (req_rot_s)
            4'b???1: gnt_off_s = 2'd0;
            4'b??10: gnt_off_s = 2'd1;
            4'b?100: gnt_off_s = 2'd2;
            4'b1000: gnt_off_s = 2'd3;
            default: gnt_any_s = 1'b0;
        endcase
        gnt_idx_s = rr_q + 2'd1 + gnt_off_s;
    end

    // Address mux for the granted requester.
    always_comb begin
        sel_addr_s = blinky_addr;
        case (gnt_idx_s)
            2'd0:    sel_addr_s = blinky_addr;
            2'd1:    sel_addr_s = pinky_addr;
            2'd2:    sel_addr_s = inky_addr;
            2'd3:    sel_addr_s = clyde_addr;
            default: sel_addr_s = blinky_addr;
        endcase
    end

    assign gnt = (rst_n && gnt_any_s) ? (4'b0001 << gnt_idx_s) : 4'b0000;

    // Next state for the pointer, stage 1 capture, stage 2 response and frill animation.
    always_comb begin
        rr_d        = rr_q;
        s1_valid_d  = gnt_any_s;
        s1_addr_d   = s1_addr_q;
        s1_dir_d    = s1_dir_q;
        s1_tag_d    = s1_tag_q;
        if (gnt_any_s) begin
            rr_d      = gnt_idx_s;
            s1_addr_d = sel_addr_s;
            s1_dir_d  = dir[gnt_idx_s];
            s1_tag_d  = gnt_idx_s;
        end else begin
            rr_d      = rr_q;
        end

        // Frame is the frill state seen while the lookup sits in stage 1.
        cls_s = decode_pixel(lut_pixel, s1_addr_q, s1_dir_q, frill_q);
        if (s1_valid_q) begin
            rsp_valid_d = 4'b0001 << s1_tag_q;
            rsp_class_d = cls_s;
        end else begin
            rsp_valid_d = 4'b0000;
            rsp_class_d = CLS_TRANS;
        end

        frill_cnt_d = frill_cnt_q;
        frill_d     = frill_q;
        if (frame_tick) begin
            if (frill_cnt_q == CNT_W'(FRILL_DIV - 1)) begin
                frill_cnt_d = '0;
                frill_d     = ~frill_q;
            end else begin
                frill_cnt_d = frill_cnt_q + CNT_W'(1);
            end
        end else begin
            frill_cnt_d = frill_cnt_q;
        end
    end

    // State registers with synchronous active-low reset; reset drops in-flight lookups.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q        <= 2'd3;
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            s1_dir_q    <= 1'b0;
            s1_tag_q    <= 2'd0;
            rsp_valid_q <= 4'b0000;
            rsp_class_q <= CLS_TRANS;
            frill_cnt_q <= '0;
            frill_q     <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            s1_valid_q  <= s1_valid_d;
            s1_addr_q   <= s1_addr_d;
            s1_dir_q    <= s1_dir_d;
            s1_tag_q    <= s1_tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_class_q <= rsp_class_d;
            frill_cnt_q <= frill_cnt_d;
            frill_q     <= frill_d;
        end
    end

    assign lut_addr    = s1_addr_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_class   = rsp_class_q;
    assign frill_frame = frill_q;

endmodule

// File: tb/tb_ghost_lut_arbiter.sv
// Directed bench for ghost_lut_arbiter: reset, round robin, decode, frill,
// out-of-range addresses and reset during an in-flight lookup.
module tb_ghost_lut_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [9:0] blinky_addr, pinky_addr, inky_addr, clyde_addr;
    logic [3:0] dir;
    logic       frame_tick;
    logic [3:0] gnt;
    logic [9:0] lut_addr;
    logic [2:0] lut_pixel;
    logic [3:0] rsp_valid;
    logic [1:0] rsp_class;
    logic       frill_frame;

    int checks   = 0;
    int failures = 0;

    logic [2:0] lut_mem [0:1023];
    logic [9:0] addr_tab [4];
    logic [1:0] cls_tab  [4];

    ghost_lut_arbiter #(.ADDR_W(10), .LUT_DEPTH(768), .FRILL_DIV(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .blinky_addr(blinky_addr), .pinky_addr(pinky_addr),
        .inky_addr(inky_addr), .clyde_addr(clyde_addr),
        .dir(dir), .frame_tick(frame_tick), .gnt(gnt),
        .lut_addr(lut_addr), .lut_pixel(lut_pixel),
        .rsp_valid(rsp_valid), .rsp_class(rsp_class),
        .frill_frame(frill_frame)
    );

    always #5 clk = ~clk;

    assign lut_pixel = lut_mem[lut_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_addr(input int idx, input logic [9:0] a);
        case (idx)
            0:       blinky_addr = a;
            1:       pinky_addr  = a;
            2:       inky_addr   = a;
            default: clyde_addr  = a;
        endcase
    endtask

    // Single lookup from one requester; checks grant and the response two cycles later.
    task automatic lookup(input string tag, input int idx, input logic [9:0] a,
                          input logic d, input logic [1:0] exp_cls);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        set_addr(idx, a);
        dir = d ? oh : 4'b0000;
        req = oh;
        #1;
        check({tag, "_gnt"}, 32'(gnt), 32'(oh));
        tick();
        req = 4'b0000;
        check({tag, "_addr"}, 32'(lut_addr), 32'(a));
        check({tag, "_early"}, 32'(rsp_valid), 32'h0);
        tick();
        check({tag, "_vld"}, 32'(rsp_valid), 32'(oh));
        check({tag, "_cls"}, 32'(rsp_class), 32'(exp_cls));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) lut_mem[i] = 3'b000;
        lut_mem[10'h010] = 3'b001;  // row1 body
        lut_mem[10'h021] = 3'b010;  // row2 eye
        lut_mem[10'h032] = 3'b101;  // row3, white when dir=1
        lut_mem[10'h043] = 3'b110;  // row4, body when dir=0
        lut_mem[10'h045] = 3'b011;  // WHT0 row4
        lut_mem[10'h104] = 3'b100;  // BLU0
        lut_mem[10'h0D5] = 3'b010;  // FRL0 row13
        lut_mem[10'h300] = 3'b001;  // beyond LUT_DEPTH
        lut_mem[10'h3FF] = 3'b001;
        addr_tab[0] = 10'h010; cls_tab[0] = 2'd1;
        addr_tab[1] = 10'h021; cls_tab[1] = 2'd2;
        addr_tab[2] = 10'h032; cls_tab[2] = 2'd3;
        addr_tab[3] = 10'h043; cls_tab[3] = 2'd1;

        rst_n = 1'b0; req = 4'hF; dir = 4'b0100; frame_tick = 1'b0;
        blinky_addr = addr_tab[0]; pinky_addr = addr_tab[1];
        inky_addr = addr_tab[2];   clyde_addr = addr_tab[3];

        // Reset with all requests pending
        tick(); tick(); tick();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_rsp", 32'(rsp_valid), 32'h0);
        check("rst_addr", 32'(lut_addr), 32'h0);
        check("rst_frill", 32'(frill_frame), 32'h0);
        check("rst_cls", 32'(rsp_class), 32'h0);

        // Round robin with all four requesting for 8 cycles
        rst_n = 1'b1;
        for (int k = 0; k < 11; k++) begin
            if (k == 8) req = 4'h0;
            #1;
            check("rr_gnt", 32'(gnt), (k < 8) ? 32'(4'b0001 << (k % 4)) : 32'h0);
            check("rr_rsp", 32'(rsp_valid),
                  (k >= 2 && k < 10) ? 32'(4'b0001 << ((k - 2) % 4)) : 32'h0);
            if (k >= 2 && k < 10) check("rr_cls", 32'(rsp_class), 32'(cls_tab[(k - 2) % 4]));
            if (k >= 1 && k < 9) check("rr_addr", 32'(lut_addr), 32'(addr_tab[(k - 1) % 4]));
            tick();
        end

        // Direction-dependent decode
        lookup("wht_d0", 0, 10'h045, 1'b0, 2'd3);
        lookup("wht_d1", 0, 10'h045, 1'b1, 2'd1);
        lookup("blu_d0", 0, 10'h104, 1'b0, 2'd2);

        // Frill animation
        lookup("frl_f0", 0, 10'h0D5, 1'b0, 2'd1);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("frill_7", 32'(frill_frame), 32'h0);
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
            tick();
        end
        check("frill_8", 32'(frill_frame), 32'h1);
        lookup("frl_f1", 0, 10'h0D5, 1'b0, 2'd0);

        // Out-of-range addresses
        lookup("oor_300", 1, 10'h300, 1'b0, 2'd0);
        lookup("oor_3ff", 1, 10'h3FF, 1'b0, 2'd0);

        // Reset while an inky lookup is in flight
        inky_addr = 10'h032; dir = 4'b0100; req = 4'b0100;
        #1;
        check("mid_gnt", 32'(gnt), 32'h4);
        tick();
        req = 4'b0000; rst_n = 1'b0;
        #1;
        check("mid_gnt_rst", 32'(gnt), 32'h0);
        tick();
        check("mid_rsp0", 32'(rsp_valid), 32'h0);
        tick();
        check("mid_rsp1", 32'(rsp_valid), 32'h0);
        check("mid_frill", 32'(frill_frame), 32'h0);
        rst_n = 1'b1; clyde_addr = 10'h043; dir = 4'b0000; req = 4'h8;
        #1;
        check("post_gnt", 32'(gnt), 32'h8);
        tick();
        req = 4'h0;
        check("post_rsp_early", 32'(rsp_valid), 32'h0);
        tick();
        check("post_rsp", 32'(rsp_valid), 32'h8);
        check("post_cls", 32'(rsp_class), 32'h1);
        // Pointer now at clyde: blinky wins next
        req = 4'hF;
        #1;
        check("post_rr", 32'(gnt), 32'h1);
        req = 4'h0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
